// File: rtl/qdec_pkg.sv
// Shared types and Gray-code transition decode for the quadrature encoder receiver.
// Phase ab walks 00->10->11->01->00 when counting up.
package qdec_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } qdec_state_t;

    typedef logic [1:0] qdec_ab_t;

    typedef struct packed {
        logic valid;
        logic up;
        logic err;
    } qdec_dec_t;

    // Position of a phase within the up-counting Gray cycle.
    function automatic logic [1:0] qdec_idx(input qdec_ab_t ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic qdec_dec_t qdec_decode(input qdec_ab_t prev, input qdec_ab_t cur);
        qdec_dec_t  r;
        logic [1:0] diff;
        logic [1:0] prev_nxt;
        r        = '0;
        diff     = prev ^ cur;
        prev_nxt = qdec_idx(prev) + 2'd1;
        if (diff == 2'b11) begin
            r.err = 1'b1;
        end else if (diff != 2'b00) begin
            r.valid = 1'b1;
            r.up    = (qdec_idx(cur) == prev_nxt);
        end
        return r;
    endfunction

endpackage

// File: rtl/qdec_filt.sv
// Two-flop synchroniser plus glitch filter for one encoder channel.
// A new level is accepted only after FILT_LEN consecutive samples that differ from the output.
module qdec_filt #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic load,
    output logic dout
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          raw;

    assign raw = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], din};
        end
    end

    // load bypasses the filter so the output can settle to the pin level at start-up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            dout <= raw;
            cnt  <= '0;
        end else if (raw == dout) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            dout <= raw;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/quad_enc_decoder.sv
// Quadrature encoder receiver: filtered A/B, x4 Gray decode, wrapping position and event pulses.
// Position updates FILT_LEN+3 clocks after a pin change; simultaneous A/B changes flag err.
module quad_enc_decoder
    import qdec_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             wrap,
    output logic             ready
);

    localparam int IC_W = $clog2(FILT_LEN + 2);
    localparam logic [IC_W-1:0] INIT_LAST = IC_W'(FILT_LEN + 1);

    qdec_state_t     state, state_nxt;
    logic [IC_W-1:0] init_cnt;
    logic            filt_a, filt_b;
    qdec_ab_t        cur, prev;
    qdec_dec_t       dec;
    logic            run, cnt_step, at_max, at_zero;

    qdec_filt #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk  (clk),
        .rst  (rst),
        .din  (a),
        .load (state == INIT),
        .dout (filt_a)
    );

    qdec_filt #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk  (clk),
        .rst  (rst),
        .din  (b),
        .load (state == INIT),
        .dout (filt_b)
    );

    assign cur      = {filt_a, filt_b};
    assign dec      = qdec_decode(prev, cur);
    assign run      = (state == RUN);
    assign cnt_step = run && dec.valid && en;
    assign at_max   = (pos == {CNT_W{1'b1}});
    assign at_zero  = (pos == '0);
    assign ready    = run;

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_cnt == INIT_LAST) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                init_cnt <= init_cnt + IC_W'(1);
            end
        end
    end

    // prev follows the filtered phase even when counting is disabled, so re-enabling never miscounts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            pos  <= '0;
            step <= 1'b0;
            dir  <= 1'b0;
            err  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            prev <= cur;
            step <= cnt_step;
            err  <= run && dec.err;
            wrap <= 1'b0;
            if (cnt_step) begin
                dir <= dec.up;
            end
            if (clr) begin
                pos <= '0;
            end else if (cnt_step) begin
                if (dec.up) begin
                    pos  <= pos + CNT_W'(1);
                    wrap <= at_max;
                end else begin
                    pos  <= pos - CNT_W'(1);
                    wrap <= at_zero;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Directed bench for quad_enc_decoder (CNT_W=16, FILT_LEN=4): latency, direction, wrap, filter, err, clr, en, reset.
module tb_quad_enc_decoder;

    logic        clk, rst, a, b, en, clr;
    logic [15:0] pos;
    logic        step, dir, err, wrap, ready;
    int          n_checks = 0;
    int          n_fail   = 0;

    quad_enc_decoder #(.CNT_W(16), .FILT_LEN(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .en    (en),
        .clr   (clr),
        .pos   (pos),
        .step  (step),
        .dir   (dir),
        .err   (err),
        .wrap  (wrap),
        .ready (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new phase, then check nothing fires through edge 6 and the result lands on edge 7.
    task automatic step_to(input string tag, input logic na, input logic nb, input logic use_clr,
                           input logic estep, input logic eerr, input logic [15:0] epos,
                           input logic edir, input logic ewrap);
        a = na;
        b = nb;
        repeat (6) tick();
        chk({tag, "_early_step"}, step, 0);
        chk({tag, "_early_err"}, err, 0);
        if (use_clr) clr = 1'b1;
        tick();
        clr = 1'b0;
        chk({tag, "_step"}, step, estep);
        chk({tag, "_err"}, err, eerr);
        chk({tag, "_pos"}, pos, epos);
        chk({tag, "_dir"}, dir, edir);
        chk({tag, "_wrap"}, wrap, ewrap);
        tick();
        chk({tag, "_step_end"}, step, 0);
        chk({tag, "_err_end"}, err, 0);
        chk({tag, "_wrap_end"}, wrap, 0);
    endtask

    initial begin
        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b1;
        en  = 1'b1;
        clr = 1'b0;
        #12;
        chk("rst_pos", pos, 0);
        chk("rst_ready", ready, 0);
        chk("rst_flags", {step, dir, err, wrap}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Start-up with a=b=1: ready after 6 edges, no spurious events
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("init_ready_%0d", i), ready, (i == 6) ? 1 : 0);
            chk($sformatf("init_ev_%0d", i), {step, err}, 0);
        end
        repeat (4) begin
            tick();
            chk("post_init_ev", {step, err, pos}, 0);
        end

        // Clockwise cycle from 11
        step_to("cw1", 0, 1, 0, 1, 0, 16'd1, 1, 0);
        step_to("cw2", 0, 0, 0, 1, 0, 16'd2, 1, 0);
        step_to("cw3", 1, 0, 0, 1, 0, 16'd3, 1, 0);
        step_to("cw4", 1, 1, 0, 1, 0, 16'd4, 1, 0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_pos", pos, 0);
        chk("clr_step", step, 0);

        // Counter-clockwise cycle from 11, wrapping below zero on the first step
        step_to("ccw1", 1, 0, 0, 1, 0, 16'hFFFF, 0, 1);
        step_to("ccw2", 0, 0, 0, 1, 0, 16'hFFFE, 0, 0);
        step_to("ccw3", 0, 1, 0, 1, 0, 16'hFFFD, 0, 0);
        step_to("ccw4", 1, 1, 0, 1, 0, 16'hFFFC, 0, 0);

        // 3-cycle glitches on a are rejected
        repeat (2) begin
            a = 1'b0;
            repeat (3) tick();
            a = 1'b1;
            repeat (3) tick();
        end
        repeat (8) begin
            tick();
            chk("bounce_step", step, 0);
            chk("bounce_pos", pos, 16'hFFFC);
        end

        // Exactly 4-cycle low pulse on a: counted up then back down
        a = 1'b0;
        repeat (4) tick();
        a = 1'b1;
        tick();
        tick();
        chk("p4_early", step, 0);
        tick();
        chk("p4_up_step", step, 1);
        chk("p4_up_pos", pos, 16'hFFFD);
        chk("p4_up_dir", dir, 1);
        repeat (3) tick();
        chk("p4_mid", step, 0);
        tick();
        chk("p4_dn_step", step, 1);
        chk("p4_dn_pos", pos, 16'hFFFC);
        chk("p4_dn_dir", dir, 0);
        tick();

        // Move to 00, then jump both channels to 11
        step_to("pre_err1", 0, 1, 0, 1, 0, 16'hFFFD, 1, 0);
        step_to("pre_err2", 0, 0, 0, 1, 0, 16'hFFFE, 1, 0);
        step_to("err", 1, 1, 0, 0, 1, 16'hFFFE, 1, 0);
        step_to("post_err", 0, 1, 0, 1, 0, 16'hFFFF, 1, 0);
        step_to("wrap_up", 0, 0, 0, 1, 0, 16'h0000, 1, 1);

        // clr coincident with a step
        step_to("pre_clr", 1, 0, 0, 1, 0, 16'd1, 1, 0);
        step_to("clr_step", 1, 1, 1, 1, 0, 16'd0, 1, 0);

        // en=0: phase tracked, nothing counted; then resume
        en = 1'b0;
        step_to("en_off", 1, 0, 0, 0, 0, 16'd0, 1, 0);
        en = 1'b1;
        step_to("en_on", 0, 0, 0, 1, 0, 16'hFFFF, 0, 1);

        // Asynchronous reset mid-step
        a = 1'b1;
        b = 1'b0;
        repeat (3) tick();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_pos", pos, 0);
        chk("mid_rst_flags", {step, dir, err, wrap}, 0);
        chk("mid_rst_ready", ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("rerun_ready_%0d", i), ready, (i == 6) ? 1 : 0);
            chk($sformatf("rerun_ev_%0d", i), {step, err}, 0);
        end
        repeat (3) tick();
        chk("rerun_pos", pos, 0);
        step_to("rerun_step", 1, 1, 0, 1, 0, 16'd1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
